// File: rtl/axis_matvec_acc.sv
// Tiled AXI-Stream matrix-vector multiply-accumulate, y = sum over tiles of K_tile * x_tile.
// Define MATVEC_ACC_TCNT_EN to add m_axis_y_tuser: the number of tiles folded into y.

module axis_matvec_acc_row #(
   parameter int C      = 8,
   parameter int W_X    = 8,
   parameter int W_K    = 8,
   parameter int W_Y    = 23,
   parameter int SIGNED = 1
) (
   input  logic [C-1:0][W_K-1:0] k_row,
   input  logic [C-1:0][W_X-1:0] x,
   input  logic [W_Y-1:0]        acc,
   output logic [W_Y-1:0]        acc_sum
);
   // Operands are extended to W_Y and multiplied modulo 2^W_Y, which gives the
   // exact two's-complement or unsigned result as long as the sum fits in W_Y.
   logic [W_Y-1:0] k_e, x_e, p;

   always_comb begin
      p   = '0;
      k_e = '0;
      x_e = '0;
      for (int c = 0; c < C; c++) begin
         k_e = {{(W_Y-W_K){(SIGNED != 0) & k_row[c][W_K-1]}}, k_row[c]};
         x_e = {{(W_Y-W_X){(SIGNED != 0) & x[c][W_X-1]}}, x[c]};
         p   = p + k_e * x_e;
      end
   end

   assign acc_sum = acc + p;
endmodule

module axis_matvec_acc #(
   parameter int R         = 8,
   parameter int C         = 8,
   parameter int W_X       = 8,
   parameter int W_K       = 8,
   parameter int MAX_TILES = 16,
   parameter int SIGNED    = 1
) (
   input  logic                                           clk,
   input  logic                                           rstn,
   input  logic                                           s_axis_kx_tvalid,
   output logic                                           s_axis_kx_tready,
   input  logic [R*C*W_K+C*W_X-1:0]                       s_axis_kx_tdata,
   input  logic                                           s_axis_kx_tlast,
   output logic                                           m_axis_y_tvalid,
   input  logic                                           m_axis_y_tready,
   output logic [R*(W_X+W_K+$clog2(C*MAX_TILES))-1:0]     m_axis_y_tdata,
`ifdef MATVEC_ACC_TCNT_EN
   output logic [$clog2(MAX_TILES+1)-1:0]                 m_axis_y_tuser,
`endif
   output logic                                           err_overrun
);
   localparam int W_Y  = W_X + W_K + $clog2(C*MAX_TILES);
   localparam int TW   = $clog2(MAX_TILES + 1);
   localparam int W_XB = C * W_X;
   localparam int W_KB = R * C * W_K;

   logic [R-1:0][C-1:0][W_K-1:0] k;
   logic [C-1:0][W_X-1:0]        x;
   logic [R-1:0][W_Y-1:0]        acc, acc_sum, y_q;
   logic [TW-1:0]                tile_cnt;
   logic                         rstn_q, beat, last_beat;

   assign x              = s_axis_kx_tdata[W_XB-1:0];
   assign k              = s_axis_kx_tdata[W_XB +: W_KB];
   assign m_axis_y_tdata = y_q;

   // Accept whenever the output slot is empty or is being drained this cycle.
   assign s_axis_kx_tready = rstn_q & (~m_axis_y_tvalid | m_axis_y_tready);
   assign beat             = s_axis_kx_tvalid & s_axis_kx_tready;
   assign last_beat        = s_axis_kx_tlast | (tile_cnt == TW'(MAX_TILES - 1));

   for (genvar r = 0; r < R; r++) begin : g_row
      axis_matvec_acc_row #(
         .C(C), .W_X(W_X), .W_K(W_K), .W_Y(W_Y), .SIGNED(SIGNED)
      ) u_row (
         .k_row   (k[r]),
         .x       (x),
         .acc     (acc[r]),
         .acc_sum (acc_sum[r])
      );
   end

   // tile_cnt==0 is the idle state; any nonzero count means a packet is open.
   always_ff @(posedge clk) begin
      rstn_q <= rstn;
      if (!rstn) begin
         m_axis_y_tvalid <= 1'b0;
         y_q             <= '0;
         err_overrun     <= 1'b0;
         acc             <= '0;
         tile_cnt        <= '0;
      end else begin
         if (m_axis_y_tready)
            m_axis_y_tvalid <= 1'b0;
         if (beat) begin
            if (last_beat) begin
               y_q             <= acc_sum;
               m_axis_y_tvalid <= 1'b1;
               acc             <= '0;
               tile_cnt        <= '0;
               if (!s_axis_kx_tlast)
                  err_overrun <= 1'b1;
            end else begin
               acc      <= acc_sum;
               tile_cnt <= tile_cnt + TW'(1);
            end
         end
      end
   end

`ifdef MATVEC_ACC_TCNT_EN
   always_ff @(posedge clk) begin
      if (!rstn)
         m_axis_y_tuser <= '0;
      else if (beat && last_beat)
         m_axis_y_tuser <= tile_cnt + TW'(1);
   end
`endif
endmodule
